mem_ctrl: RTL
=============

// Module: mem_ctrl
// PURPOSE
//   Single-port memory controller between the byte-wide RAM/IO bus and two clients: the LSB (data load/store) and instruction fetch.
//   Serialises each request into byte transfers, assembles and sign/zero-extends load data, and returns one-cycle completion pulses.
//   Drives the cache_ready / cache_welcome_signal / is_load / load_val_out handshake the LSB consumes.
// PARAMETERS
//   IO_SEL_HI   17       upper bit of IO-select field; IO space when addr[IO_SEL_HI:IO_SEL_HI-1]==2'b11
//   LSB_FIRST   1        1: LSB request wins over fetch when both pending in IDLE
// PORTS
//   clk_in                in   1   system clock; single clock domain
//   rst_n_in              in   1   reset, asynchronous, active-low
//   rdy_in                in   1   global ready; low freezes block
//   rob_clear_up          in   1   pipeline flush
//   lsb_visit_mem         in   1   LSB request valid, held until cache_ready seen
//   op_type_in            in   7   opcode: `LD_TYPE (0000011) or `ST_TYPE (0100011)
//   op_in                 in   3   funct3: 0 B, 1 H, 2 W, 4 BU, 5 HU
//   addr_in               in   32  byte address
//   store_val_in          in   32  store data, little-endian
//   cache_welcome_signal  out  1   controller can accept a new LSB request this cycle
//   cache_ready           out  1   one-cycle completion pulse for LSB access
//   is_load               out  1   qualifies cache_ready: 1 = completed access was a load
//   load_val_out          out  32  extended load result, valid with cache_ready
//   if_req                in   1   fetch request valid, held until if_ready
//   if_addr               in   32  fetch word address
//   if_ready              out  1   one-cycle fetch completion pulse
//   if_inst               out  32  fetched instruction, valid with if_ready
//   mem_din               in   8   RAM read byte (1-cycle read latency)
//   mem_dout              out  8   RAM write byte
//   mem_a                 out  32  RAM byte address
//   mem_wr                out  1   1 = write, 0 = read
//   io_buffer_full        in   1   IO write buffer full
// BEHAVIOUR
//   Reset (async, rst_n_in low): state IDLE; all outputs 0; internal byte counter/shift register cleared.
//   States: IDLE, LOAD, STORE, FETCH, DONE.
//   IDLE: welcome = 1 unless cache_ready is high. If lsb_visit_mem (and LSB_FIRST or no if_req): latch addr/op/data, go LOAD or STORE. Else if if_req: go FETCH.
//     In IDLE mem_a = 0 and mem_wr = 0; no IO-space address is ever presented while idle.
//   N bytes: 1 (B/BU), 2 (H/HU), 4 (W, fetch).
//   LOAD/FETCH: cycle k (k=1..N) presents mem_a = addr+k-1. Byte k-1 arrives on mem_din in cycle k+1 and is sampled at that cycle's closing edge.
//     Result pulse is high in cycle N+2 (cycle 0 = acceptance cycle). LW: ready in cycle 6.
//   STORE: cycle k drives mem_a = addr+k-1, mem_dout = byte k-1, mem_wr = 1. cache_ready is high in cycle N+1 with is_load = 0.
//   IO stall: while addr is in IO space and io_buffer_full = 1, no write byte is issued (mem_wr = 0) and the counter holds.
//   Load extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
//     load_val_out is held until the next completion. is_load = 0 on store pulses.
//   DONE: one cycle, welcome = 0, then IDLE. This absorbs the LSB dropping lsb_visit_mem one edge after cache_ready.
//   Pulses: cache_ready and if_ready are never high together and are never high for more than one cycle.
//   rob_clear_up:
//     In LOAD/FETCH: abort at that edge, go IDLE, and suppress the pending pulse.
//     In STORE: finish all remaining bytes (the store is committed), but cache_ready stays low; welcome stays low until IDLE.
//     In IDLE/DONE: no effect; a same-cycle request is ignored.
//   rdy_in low: all state and counters frozen. mem_wr is forced 0 combinationally (no duplicate writes), and pulses stretch until rdy_in returns.
//   Widths: mem_a = base + counter (32-bit, wraps modulo 2^32). Counter is 3 bits.
// STRUCTURE
//   Shared Const.v: `LD_TYPE, `ST_TYPE, funct3 width codes, MC state encodings, IO-space test macro.
//   Sub-module mem_ctrl_ext: combinational byte assemble + sign/zero extend (op, 32-bit raw -> 32-bit result).
//   Top holds the FSM, byte counter, shift register, arbiter and output registers.
// TESTING
//   1. LW addr 0x100, RAM bytes 78 56 34 12 -> mem_a 0x100..0x103 in cycles 1-4; cache_ready+is_load in cycle 6; load_val_out 0x12345678.
//   2. LB addr 0x200 holding 0x80 -> 0xFFFFFF80; LBU -> 0x00000080; LH 0x8001 -> 0xFFFF8001; each ready in cycle N+2.
//   3. SH addr 0x300 data 0xAABBCCDD -> writes CC@0x301 after DD@0x300, mem_wr=1 in cycles 1-2; cache_ready in cycle 3, is_load=0.
//   4. SB addr 0x30000 with io_buffer_full high 5 cycles -> mem_wr stays 0 through the stall; one write after; exactly one ready pulse.
//   5. lsb_visit_mem and if_req in same IDLE cycle -> LSB served first; fetch starts after DONE; if_inst correct; pulses never overlap.
//   6. rob_clear_up mid-LW -> no cache_ready, IDLE next cycle. rob_clear_up mid-SW -> all 4 bytes written, no pulse. rst_n_in low mid-op -> all outputs 0 immediately.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared constants, state encoding and small helpers for the byte-serial memory controller.
package mem_ctrl_pkg;

    localparam logic [6:0] LD_TYPE = 7'b0000011;
    localparam logic [6:0] ST_TYPE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [2:0] {
        MC_IDLE,
        MC_LOAD,
        MC_STORE,
        MC_FETCH,
        MC_DONE
    } mc_state_e;

    // Transfer length in bytes from the low two funct3 bits.
    function automatic logic [2:0] nbytes(input logic [1:0] f3_lo);
        case (f3_lo)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic is_io(input logic [1:0] sel);
        return sel == 2'b11;
    endfunction

endpackage

// File: rtl/mem_ctrl_ext.sv
// Load-result extension: picks the low byte/half of the assembled word and sign/zero extends it.
module mem_ctrl_ext
    import mem_ctrl_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [31:0] raw_i,
    output logic [31:0] val_o
);

    always_comb begin
        val_o = raw_i;
        case (op_i)
            F3_B:    val_o = {{24{raw_i[7]}}, raw_i[7:0]};
            F3_H:    val_o = {{16{raw_i[15]}}, raw_i[15:0]};
            F3_BU:   val_o = {24'd0, raw_i[7:0]};
            F3_HU:   val_o = {16'd0, raw_i[15:0]};
            F3_W:    val_o = raw_i;
            default: val_o = raw_i;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Single-port byte-bus memory controller arbitrating LSB loads/stores and instruction fetch.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int IO_SEL_HI = 17,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        rob_clear_up,
    input  logic        lsb_visit_mem,
    input  logic [6:0]  op_type_in,
    input  logic [2:0]  op_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_val_in,
    output logic        cache_welcome_signal,
    output logic        cache_ready,
    output logic        is_load,
    output logic [31:0] load_val_out,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_inst,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    mc_state_e   state_q, state_d;
    logic [2:0]  cnt_q, cnt_d, len_q, len_d, op_q, op_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, raw_q, raw_d;
    logic [31:0] lval_q, lval_d, inst_q, inst_d;
    logic        flush_q, flush_d, welcome_q, welcome_d;
    logic        cready_q, cready_d, isld_q, isld_d, iready_q, iready_d;
    logic [31:0] cur_a, ext_val;
    logic [1:0]  bidx;
    logic        rd_phase, io_stall, lsb_go;

    assign cur_a    = addr_q + {29'd0, cnt_q};
    assign rd_phase = (state_q == MC_LOAD) || (state_q == MC_FETCH);
    assign io_stall = is_io(cur_a[IO_SEL_HI:IO_SEL_HI-1]) && io_buffer_full;
    assign bidx     = cnt_q[1:0] - 2'd1;
    assign lsb_go   = lsb_visit_mem && (op_type_in == LD_TYPE || op_type_in == ST_TYPE)
                      && (LSB_FIRST || !if_req);

    // The read address is dropped in the final sample cycle so no stray IO read is issued.
    assign mem_a    = (state_q == MC_STORE || (rd_phase && cnt_q != len_q)) ? cur_a : 32'd0;
    assign mem_dout = (state_q == MC_STORE) ? wdata_q[{cnt_q[1:0], 3'b000} +: 8] : 8'd0;
    assign mem_wr   = (state_q == MC_STORE) && !io_stall && rdy_in;

    assign cache_welcome_signal = welcome_q;
    assign cache_ready          = cready_q;
    assign is_load              = isld_q;
    assign load_val_out         = lval_q;
    assign if_ready             = iready_q;
    assign if_inst              = inst_q;

    // Byte k-1 lands one cycle after its address, i.e. while the counter reads k.
    always_comb begin
        raw_d = raw_q;
        if (rd_phase && cnt_q != 3'd0) raw_d[{bidx, 3'b000} +: 8] = mem_din;
    end

    mem_ctrl_ext u_ext (
        .op_i  (op_q),
        .raw_i (raw_d),
        .val_o (ext_val)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        flush_d  = flush_q;
        cready_d = 1'b0;
        iready_d = 1'b0;
        isld_d   = isld_q;
        lval_d   = lval_q;
        inst_d   = inst_q;
        case (state_q)
            MC_IDLE: begin
                if (!rob_clear_up) begin
                    if (lsb_go) begin
                        addr_d  = addr_in;
                        op_d    = op_in;
                        wdata_d = store_val_in;
                        len_d   = nbytes(op_in[1:0]);
                        cnt_d   = 3'd0;
                        flush_d = 1'b0;
                        state_d = (op_type_in == ST_TYPE) ? MC_STORE : MC_LOAD;
                    end else if (if_req) begin
                        addr_d  = if_addr;
                        len_d   = 3'd4;
                        cnt_d   = 3'd0;
                        state_d = MC_FETCH;
                    end
                end
            end
            MC_LOAD, MC_FETCH: begin
                if (rob_clear_up) begin
                    state_d = MC_IDLE;
                    cnt_d   = 3'd0;
                end else if (cnt_q == len_q) begin
                    state_d = MC_DONE;
                    cnt_d   = 3'd0;
                    if (state_q == MC_LOAD) begin
                        cready_d = 1'b1;
                        isld_d   = 1'b1;
                        lval_d   = ext_val;
                    end else begin
                        iready_d = 1'b1;
                        inst_d   = raw_d;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            MC_STORE: begin
                // A flushed store still commits every byte; only its completion pulse is dropped.
                if (rob_clear_up) flush_d = 1'b1;
                if (!io_stall) begin
                    if (cnt_q == len_q - 3'd1) begin
                        state_d = MC_DONE;
                        cnt_d   = 3'd0;
                        if (!(flush_q || rob_clear_up)) begin
                            cready_d = 1'b1;
                            isld_d   = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            MC_DONE:  state_d = MC_IDLE;
            default:  state_d = MC_IDLE;
        endcase
        welcome_d = (state_d == MC_IDLE) && !cready_d;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= MC_IDLE;
            cnt_q     <= 3'd0;
            len_q     <= 3'd0;
            op_q      <= 3'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            raw_q     <= 32'd0;
            flush_q   <= 1'b0;
            welcome_q <= 1'b0;
            cready_q  <= 1'b0;
            isld_q    <= 1'b0;
            iready_q  <= 1'b0;
            lval_q    <= 32'd0;
            inst_q    <= 32'd0;
        end else if (rdy_in) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            raw_q     <= raw_d;
            flush_q   <= flush_d;
            welcome_q <= welcome_d;
            cready_q  <= cready_d;
            isld_q    <= isld_d;
            iready_q  <= iready_d;
            lval_q    <= lval_d;
            inst_q    <= inst_d;
        end
    end

endmodule
